// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus bundle: imem request/response, redirect, decode handoff
// FETCH_MISALIGN_CHECK_EN adds the id_misalign signal.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        id_misalign;
`endif

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_inst,
    output id_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    , output id_misalign
`endif
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_inst,
    input  id_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    , input id_misalign
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction fetch stage with credit-limited fetch buffer
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect reporting).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 3
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  localparam int              CW    = $clog2(DEPTH + 1);
  localparam int              PW    = $clog2(DEPTH);
  localparam logic [CW:0]     LIMIT = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST  = PW'(DEPTH - 1);
  localparam logic [31:0]     NOP   = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_inst [DEPTH];

  logic [31:0]   target;
  logic          fetch_en;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted;
  logic mis_redirect;
  logic buf_mis [DEPTH];

  assign mis_redirect    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign fetch_en        = !halted;
  assign bus.id_misalign = buf_mis[rd_ptr];
`else
  assign fetch_en = 1'b1;
`endif

  // Low address bits are dropped so fetch always stays word aligned.
  assign target = bus.redirect_pc & 32'hFFFF_FFFC;

  // A request only goes out when a buffer slot is already reserved for its response.
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && fetch_en &&
                              (({1'b0, outstanding} + {1'b0, count}) < LIMIT);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_drop = bus.imem_rsp_valid && (drop != '0);
  assign push     = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;

  assign bus.id_valid = (count != '0) && !bus.redirect_valid;
  assign bus.id_inst  = buf_inst[rd_ptr];
  assign bus.id_pc    = buf_pc[rd_ptr];
  assign pop          = bus.id_valid && bus.id_ready;

  // Fetch address and the address to tag onto the next kept response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= target;
      rsp_pc   <= target;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push)     rsp_pc   <= rsp_pc + 32'd4;
    end
  end

  // In-flight request tracking; a redirect turns every still-pending response into a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      drop        <= '0;
    end else if (bus.redirect_valid) begin
      outstanding <= outstanding - CW'(bus.imem_rsp_valid);
      drop        <= outstanding - CW'(bus.imem_rsp_valid);
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      drop        <= drop - CW'(rsp_drop);
    end
  end

  // Circular buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      rd_ptr <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (mis_redirect) begin
        wr_ptr <= PW'(1);
        count  <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
`else
      wr_ptr <= '0;
      count  <= '0;
`endif
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Buffer entry storage: responses land at wr_ptr, a misaligned redirect leaves a NOP in slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        buf_mis[i]  <= 1'b0;
`endif
      end
    end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (mis_redirect) begin
        buf_pc[0]   <= bus.redirect_pc;
        buf_inst[0] <= NOP;
        buf_mis[0]  <= 1'b1;
      end else
`endif
      if (push) begin
        buf_pc[wr_ptr]   <= rsp_pc;
        buf_inst[wr_ptr] <= bus.imem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
        buf_mis[wr_ptr]  <= 1'b0;
`endif
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Fetch stops after a misaligned redirect and resumes on the next redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (bus.redirect_valid) begin
      halted <= mis_redirect;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with in-order latency memory model
module tb_fetch_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   lat;
  int   pops;
  logic mon_en;
  logic [31:0] exp_pc;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h100), .DEPTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t mq[$];

  typedef struct {
    logic        idr;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;
  vec_t tab[13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory: record accepted requests, never more than 3 outstanding
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
    end else if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("max_outstanding", 32'(mq.size() < 3), 32'd1);
      mq.push_back('{bus.imem_req_addr, cyc + lat});
    end
  end

  // memory: return responses in order once their latency has elapsed
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (reset) begin
      bus.imem_rsp_valid = 1'b0;
      mq.delete();
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = inst_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
    end
  end

  // decode-side scoreboard: every transfer must be the next sequential PC
  always @(negedge clk) begin
    if (!reset && mon_en && bus.id_valid && bus.id_ready) begin
      chk("mon_pc", bus.id_pc, exp_pc);
      chk("mon_inst", bus.id_inst, inst_of(exp_pc));
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mon_misalign", 32'(bus.id_misalign), 32'd0);
`endif
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; lat = 1; pops = 0;
    mon_en = 1'b0; exp_pc = 32'h100;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;

    tab[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tab[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tab[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tab[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tab[4]  = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    tab[5]  = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
    tab[6]  = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h110};
    tab[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h110};
    tab[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h110};
    tab[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h110};
    tab[10] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h114};
    tab[11] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h118};
    tab[12] = '{1'b1, 1'b1, 32'h124, 1'b1, 32'h11C};

    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_inst", bus.id_inst, 32'h0);
    chk("rst_id_pc", bus.id_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_id_misalign", 32'(bus.id_misalign), 32'd0);
`endif

    // startup and short stall, cycle by cycle
    tick();
    reset = 1'b0;
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.id_ready = tab[i].idr;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tab[i].rv));
      if (tab[i].rv) chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, tab[i].addr);
      chk($sformatf("vec%0d_id_valid", i), 32'(bus.id_valid), 32'(tab[i].iv));
      if (tab[i].iv) begin
        chk($sformatf("vec%0d_id_pc", i), bus.id_pc, tab[i].ipc);
        chk($sformatf("vec%0d_id_inst", i), bus.id_inst, inst_of(tab[i].ipc));
      end
      tick();
    end

    // 10-cycle decode stall: buffer fills, fetch stops, head entry holds
    exp_pc = 32'h120;
    mon_en = 1'b1;
    bus.id_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_id_pc", bus.id_pc, exp_pc);
      chk("stall_id_inst", bus.id_inst, inst_of(exp_pc));
      if (k >= 1) chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      tick();
    end
    bus.id_ready = 1'b1;
    repeat (10) tick();

    // latency 4 with toggling request ready
    lat = 4;
    for (int i = 0; i < 40; i++) begin
      bus.imem_req_ready = i[0];
      tick();
    end
    bus.imem_req_ready = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("drain_id_valid", 32'(bus.id_valid), 32'd0);
    chk("drain_mq", 32'(mq.size()), 32'd0);

    // redirect with one buffered entry and two requests in flight
    tick();
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    repeat (5) tick();
    bus.imem_req_ready = 1'b1;
    repeat (2) tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    exp_pc = 32'h200;
    @(negedge clk);
    chk("redir1_inflight", 32'(mq.size()), 32'd2);
    chk("redir1_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("redir1_id_valid", 32'(bus.id_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("redir1_first_req", 32'(bus.imem_req_valid), 32'd1);
    chk("redir1_first_addr", bus.imem_req_addr, 32'h200);
    tick();
    repeat (15) tick();
    chk("redir1_target_seen", 32'(exp_pc > 32'h200), 32'd1);

    // redirect during a decode transfer with a response arriving the same cycle
    lat = 1;
    repeat (8) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h400;
    exp_pc = 32'h400;
    @(negedge clk);
    chk("redir2_rsp_same_cycle", 32'(bus.imem_rsp_valid), 32'd1);
    chk("redir2_id_valid", 32'(bus.id_valid), 32'd0);
    chk("redir2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir2_r1_req_addr", bus.imem_req_addr, 32'h400);
    chk("redir2_r1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("redir2_r1_id_valid", 32'(bus.id_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("redir2_r2_id_valid", 32'(bus.id_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("redir2_r3_id_valid", 32'(bus.id_valid), 32'd1);
    chk("redir2_r3_id_pc", bus.id_pc, 32'h400);
    chk("redir2_r3_id_inst", bus.id_inst, inst_of(32'h400));
    tick();
    repeat (4) tick();

    // PC wraps past the top of the address space
    bus.redirect_valid = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    bus.redirect_pc = 32'hFFFF_FFF8;
`else
    bus.redirect_pc = 32'hFFFF_FFFB;
`endif
    exp_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_first_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
    tick();
    @(negedge clk);
    chk("wrap_second_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_third_addr", bus.imem_req_addr, 32'h0000_0000);
    tick();
    repeat (6) tick();
    chk("wrap_exp_pc_wrapped", 32'(exp_pc < 32'h100), 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
    // misaligned redirect: single NOP entry, then fetch halts
    mon_en = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h202;
    @(negedge clk);
    chk("mis_r0_id_valid", 32'(bus.id_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mis_id_valid", 32'(bus.id_valid), 32'd1);
      chk("mis_id_misalign", 32'(bus.id_misalign), 32'd1);
      chk("mis_id_inst", bus.id_inst, 32'h0000_0013);
      chk("mis_id_pc", bus.id_pc, 32'h202);
      chk("mis_req_valid", 32'(bus.imem_req_valid), 32'd0);
      tick();
    end
    bus.id_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mis_halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("mis_halt_id_valid", 32'(bus.id_valid), 32'd0);
      tick();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    exp_pc = 32'h300;
    mon_en = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("mis_resume_addr", bus.imem_req_addr, 32'h300);
    tick();
    repeat (6) tick();
`endif

    // asynchronous reset in the middle of traffic
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("arst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_id_pc", bus.id_pc, 32'h0);
    chk("arst_id_inst", bus.id_inst, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    exp_pc = 32'h100;
    @(negedge clk);
    chk("arst_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("arst_first_addr", bus.imem_req_addr, 32'h100);
    tick();
    repeat (8) tick();
    chk("arst_resumed", 32'(exp_pc > 32'h100), 32'd1);

    chk("total_transfers", 32'(pops >= 30), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32 pipeline. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and absorbs in-order responses into a small buffer. It presents `{pc, instruction}` pairs to the decode stage, whose immediate generator and register-file read consume `id_inst`. Redirects from the branch unit flush buffered and in-flight fetches and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset
- `DEPTH`, default 3, buffer entries and maximum outstanding-plus-buffered fetches (≥2)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response valid; in order, latency ≥1 cycle, no backpressure
- `imem_rsp_data`  in  32  fetched instruction word
- `redirect_valid`  in  1  branch/jump taken, restart fetch
- `redirect_pc`  in  32  restart address
- `id_valid`  out  1  decode entry valid
- `id_ready`  in  1  decode accepts entry
- `id_inst`  out  32  instruction to decode
- `id_pc`  out  32  address of `id_inst`
- `id_misalign`  out  1  present only with `FETCH_MISALIGN_CHECK_EN`

## Operation
- State: `fetch_pc`, `rsp_pc`, `outstanding` count, `drop` count, circular buffer (DEPTH × {pc, inst}) with `rd_ptr`, `wr_ptr`, `count`.
- Request: `imem_req_valid = !redirect_valid && (outstanding + count < DEPTH)`; `imem_req_addr = fetch_pc`. On acceptance, `fetch_pc += 4` and `outstanding++`.
- Credit rule: requests are never issued without a guaranteed buffer slot; there is no combinational path from `id_ready` to `imem_req_valid`.
- Response: if `drop > 0`, discard it and decrement `drop` and `outstanding`. Otherwise write `{rsp_pc, imem_rsp_data}` at `wr_ptr`, set `rsp_pc += 4`, and decrement `outstanding`.
- Decode side: `id_valid = (count != 0) && !redirect_valid`; `id_inst`/`id_pc` come from the entry at `rd_ptr`. The entry pops on `id_valid && id_ready`.
- Redirect (single cycle):
  - Empty the buffer.
  - Set `drop <= outstanding` (including a response arriving the same cycle, which is discarded).
  - Set `fetch_pc <= rsp_pc <= {redirect_pc[31:2], 2'b00}`.
  - No request and no decode transfer occur that cycle.
- Simultaneous push and pop leaves `count` unchanged. Pointers wrap modulo DEPTH.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - `imem_req_valid=0`, `id_valid=0`, `id_inst=0`, `id_pc=0`, `id_misalign=0`
  - `fetch_pc=rsp_pc=RESET_PC`
  - all counters and pointers 0
- First request is asserted in the first cycle after `reset` deasserts.
- Latency: request accepted in cycle N with a 1-cycle memory → response in N+1 → `id_valid` in N+2.
- Throughput: with DEPTH=3 and 1-cycle memory, one instruction per cycle sustained while `id_ready=1`.
- Redirect in cycle R: first request at the target in R+1; with 1-cycle memory, the target instruction is on `id_inst` in R+3.
- `id_inst`/`id_pc` hold stable while `id_valid && !id_ready`.
- `reset` asserted mid-operation clears all state asynchronously. Responses to pre-reset requests are not expected; the memory is reset by the same signal.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` performs the flush but does not fetch.
  - It pushes one entry with `id_inst=32'h0000_0013` (NOP), `id_pc=redirect_pc` (unmasked) and `id_misalign=1`.
  - Fetch then halts until the next redirect.
  - `id_misalign` is 0 for all other entries.
- Not defined:
  - `id_misalign` port absent.
  - `redirect_pc[1:0]` is ignored (forced to 00) and fetch continues normally.

## Test plan
- Reset release, 1-cycle memory, `id_ready=1`, `RESET_PC=32'h100`:
  - requests at 100, 104, 108… on consecutive cycles
  - `id_pc`=100 two cycles after first acceptance, then one entry per cycle
- `id_ready=0` for 10 cycles:
  - `count` reaches 3, `imem_req_valid` drops to 0, `id_inst` stays stable
  - on release, ordering is preserved with no lost or duplicated PC
- Memory latency 4 with `imem_req_ready` toggling:
  - at most 3 outstanding
  - every `id_pc` = previous + 4
  - instruction words match the memory model
- Redirect to 32'h200 with 2 requests in flight and 1 buffered entry:
  - in-flight responses discarded, buffered entry dropped
  - next `id_pc`=200
  - no stale instruction ever reaches decode
- Redirect while `id_valid && id_ready`, with a response arriving the same cycle: no transfer that cycle, response discarded, next entry at target.
- With macro defined, redirect to 32'h202:
  - one entry with `id_misalign=1`, `id_inst=32'h13`, `id_pc=202`
  - no further requests until a redirect to 32'h300 resumes fetch
